mips_instr_encoder: RTL and testbench

Sequential instruction encoder and loader: the inverse of the main control decoder. It accepts decoded instruction fields (kind, registers, funct, immediate) over a valid/ready stream and packs them into 32-bit MIPS words. It writes those words into consecutive instruction-memory locations starting at word 0. It sits in the test/boot path ahead of the instruction memory and lets benches and the boot loader build programs without hand-assembled hex.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_instr_encoder_if.sv | 23 ++
 rtl/mips_instr_pack.sv | 31 +++
 rtl/mips_instr_encoder.sv | 105 ++++++++++
 tb/tb_mips_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction-kind encoding and
// the encoder FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Codes 5..7 on the 3-bit kind field are illegal and have no enumerator.
  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Decoded-instruction stream into the encoder: fields plus valid/ready/last.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_instr_pack.sv
// Combinational packing of decoded fields into a 32-bit MIPS word.
// bimm is the already-resolved BEQ offset field; illegal flags kinds 5..7.
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [15:0] bimm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, bimm};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential instruction encoder/loader writing packed words to imem from 0.
// Optional MIPS_ENC_BRANCH_REL_EN: BEQ in_imm is an absolute target address.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips_instr_encoder_if.slave in_if,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                err,
  output logic [ADDR_W:0]     count
);

  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic [15:0]       bimm;
  logic              illegal;
  logic              accept;
  logic              load;

  assign busy            = (state == ST_RUN);
  assign done            = (state == ST_DONE);
  assign in_if.in_ready  = busy && !full;
  assign accept          = in_if.in_valid && in_if.in_ready;
  assign load            = start && (state != ST_RUN);

  // Relative branch offset is measured from the word after this one.
`ifdef MIPS_ENC_BRANCH_REL_EN
  assign bimm = in_if.in_imm - (16'(ptr) + 16'd1);
`else
  assign bimm = in_if.in_imm;
`endif

  mips_instr_pack u_pack (
    .kind    (in_if.in_kind),
    .rs      (in_if.in_rs),
    .rt      (in_if.in_rt),
    .rd      (in_if.in_rd),
    .shamt   (in_if.in_shamt),
    .funct   (in_if.in_funct),
    .imm     (in_if.in_imm),
    .bimm    (bimm),
    .word    (word),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The accept that fills the last free word ends the load like in_last does.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && (in_if.in_last || (!illegal && count == LAST_CNT)))
                 state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      ptr        <= '0;
      count      <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
    end else begin
      imem_we <= accept && !illegal;
      if (load) begin
        ptr   <= '0;
        count <= '0;
        err   <= 1'b0;
        full  <= 1'b0;
      end else if (accept) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          imem_addr  <= ptr;
          imem_wdata <= word;
          ptr        <= ptr + 1'b1;
          count      <= count + 1'b1;
          if (count == LAST_CNT) full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed and random loads are
// checked against an arithmetic reference model of the instruction formats.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int CAP    = 1 << ADDR_W;
`ifdef MIPS_ENC_BRANCH_REL_EN
  localparam bit BRANCH_REL = 1'b1;
`else
  localparam bit BRANCH_REL = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, full, err;
  logic [ADDR_W:0]   count;

  mips_instr_encoder_if in_if ();

  mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_if      (in_if.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sbQ[$];

  bit mRun, mDone, mErr, mFull;
  int mPtr, mCount;

  // MIPS formats built from field weights: op<<26, rs<<21, rt<<16, rd<<11, shamt<<6.
  function automatic logic [31:0] refEncode(int kind, int rs, int rt, int rd, int shamt,
                                            int funct, int imm, int addr);
    longint w;
    int     opc[5];
    int     field;
    opc = '{0, 'h23, 'h2B, 'h04, 'h08};
    if (kind == 0) begin
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
        + longint'(shamt) * 64 + longint'(funct);
    end else begin
      field = imm;
      if (kind == 3 && BRANCH_REL) field = (imm - (addr + 1) + 65536) % 65536;
      w = longint'(opc[kind]) * 67108864 + longint'(rs) * 2097152
        + longint'(rt) * 65536 + longint'(field);
    end
    return w[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_strobe: got write addr %0h data %0h, expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = sbQ.pop_front();
        checkOutput("imem_addr", 32'(imem_addr), e.addr);
        checkOutput("imem_wdata", imem_wdata, e.data);
        checkOutput("count_at_write", 32'(count), e.cnt);
      end
    end
  end

  task automatic modelReset();
    mRun = 0; mDone = 0; mErr = 0; mFull = 0; mPtr = 0; mCount = 0;
    sbQ.delete();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_imem_we", 32'(imem_we), 0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 0);
    checkOutput("rst_imem_wdata", imem_wdata, 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_in_ready", 32'(in_if.in_ready), 0);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(mRun));
    checkOutput({tag, "_done"}, 32'(done), 32'(mDone));
    checkOutput({tag, "_full"}, 32'(full), 32'(mFull));
    checkOutput({tag, "_err"}, 32'(err), 32'(mErr));
    checkOutput({tag, "_count"}, 32'(count), mCount);
    checkOutput({tag, "_in_ready"}, 32'(in_if.in_ready), 32'(mRun && !mFull));
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!mRun) begin
      mRun = 1; mDone = 0; mErr = 0; mFull = 0; mPtr = 0; mCount = 0;
    end
  endtask

  task automatic idleCycles(input int n);
    in_if.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Offers one beat for one edge; the model decides whether it is taken.
  task automatic applyStimulus(input int kind, input int rs, input int rt, input int rd,
                               input int shamt, input int funct, input int imm, input bit last);
    exp_t e;
    in_if.in_valid = 1'b1;
    in_if.in_kind  = 3'(kind);
    in_if.in_rs    = 5'(rs);
    in_if.in_rt    = 5'(rt);
    in_if.in_rd    = 5'(rd);
    in_if.in_shamt = 5'(shamt);
    in_if.in_funct = 6'(funct);
    in_if.in_imm   = 16'(imm);
    in_if.in_last  = last;
    @(negedge clk);
    checkOutput("in_ready", 32'(in_if.in_ready), 32'(mRun && !mFull));
    @(posedge clk); #1;
    if (mRun && !mFull) begin
      if (kind > 4) begin
        mErr = 1;
      end else begin
        e.addr = mPtr;
        e.data = refEncode(kind, rs, rt, rd, shamt, funct, imm, mPtr);
        e.cnt  = mCount + 1;
        sbQ.push_back(e);
        mPtr   = (mPtr + 1) % CAP;
        mCount = mCount + 1;
        if (mCount == CAP) mFull = 1;
      end
      if (last || mFull) begin
        mRun = 0; mDone = 1;
      end
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  task automatic randomBeat(input bit allowIllegal, input bit last);
    int kind;
    if (allowIllegal && $urandom_range(0, 7) == 0) kind = $urandom_range(5, 7);
    else kind = $urandom_range(0, 4);
    applyStimulus(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535), last);
  endtask

  task automatic drainCheck(input string tag);
    idleCycles(2);
    checkOutput({tag, "_sb_pending"}, 32'(sbQ.size()), 0);
    sbQ.delete();
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_kind  = '0;
    in_if.in_rs    = '0;
    in_if.in_rt    = '0;
    in_if.in_rd    = '0;
    in_if.in_shamt = '0;
    in_if.in_funct = '0;
    in_if.in_imm   = '0;
    in_if.in_last  = 1'b0;
    modelReset();

    #2 checkResetOutputs();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checkStatus("idle");

    // Single R-type with last.
    doStart();
    checkStatus("started");
    applyStimulus(0, 1, 2, 3, 0, 'h20, 0, 1);
    checkStatus("single");
    drainCheck("single");

    // Back-to-back LW, SW, ADDI, R-type.
    doStart();
    applyStimulus(1, 0, 8, 0, 0, 0, 4, 0);
    applyStimulus(2, 0, 8, 0, 0, 0, 8, 0);
    applyStimulus(4, 8, 9, 0, 0, 0, 'hFFFF, 0);
    applyStimulus(0, 9, 8, 10, 2, 'h22, 0, 1);
    checkStatus("b2b");
    drainCheck("b2b");

    // BEQ landing at address 3.
    doStart();
    for (int i = 0; i < 3; i++) randomBeat(0, 0);
    applyStimulus(3, 1, 2, 0, 0, 0, 0, 1);
    checkStatus("beq");
    drainCheck("beq");

    // Illegal kind mid-stream, then an illegal beat that ends the load.
    doStart();
    applyStimulus(0, 4, 5, 6, 0, 'h24, 0, 0);
    applyStimulus(6, 1, 1, 1, 1, 1, 1, 0);
    checkStatus("illegal_mid");
    applyStimulus(1, 3, 7, 0, 0, 0, 'h10, 0);
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 1);
    checkStatus("illegal_last");
    drainCheck("illegal");

    // Fill every word without last; the extra beat must be refused.
    doStart();
    for (int i = 0; i < CAP; i++) randomBeat(0, 0);
    checkStatus("full");
    applyStimulus(0, 1, 1, 1, 1, 1, 0, 0);
    checkStatus("after_full");
    drainCheck("full");

    // Random loads with gaps, illegal kinds and ignored mid-run starts.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      doStart();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) idleCycles(1);
        if ($urandom_range(0, 9) == 0) doStart();
        randomBeat(1, i == n - 1);
      end
      checkStatus("rand");
      drainCheck("rand");
    end

    // Reset with a write just registered; nothing may survive it.
    doStart();
    applyStimulus(1, 2, 3, 0, 0, 0, 'h40, 0);
    applyStimulus(4, 2, 3, 0, 0, 0, 'h41, 0);
    rst_n = 1'b0;
    modelReset();
    #1 checkResetOutputs();
    #2 rst_n = 1'b1;
    idleCycles(3);
    checkStatus("post_reset");
    doStart();
    applyStimulus(2, 5, 6, 0, 0, 0, 'h1234, 1);
    checkStatus("restart");
    drainCheck("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
